// File: rtl/i2c_eeprom_slave_if.sv
// i2c_eeprom_slave_if: SCL input plus the busy and write-commit sideband of the EEPROM target.
`timescale 1ns/1ps
interface i2c_eeprom_slave_if;
    logic       i2c_SCL;
    logic       busy;
    logic       wr_strobe;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    modport master (output i2c_SCL, input busy, wr_strobe, wr_addr, wr_data);
    modport slave  (input i2c_SCL, output busy, wr_strobe, wr_addr, wr_data);
endinterface

// File: rtl/i2c_eeprom_slave.sv
// i2c_eeprom_slave: 24Cxx-style I2C byte EEPROM target with auto-incrementing word pointer.
`timescale 1ns/1ps
module i2c_eeprom_slave #(
    parameter logic [6:0] SLV_ADDR   = 7'h50,
    parameter int         MEM_DEPTH  = 256,
    parameter logic [7:0] INIT_VALUE = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    i2c_eeprom_slave_if.slave bus,
    inout  wire               i2c_SDA
);
    localparam int AW = $clog2(MEM_DEPTH);
    typedef enum logic [3:0] {
        IDLE, DEV_ADDR, DEV_ACK, WORD_ADDR, WORD_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;
    state_t        state, state_n;
    logic [1:0]    scl_m, sda_m;
    logic          scl_d, sda_d;
    logic          scl_rise, scl_fall, start, stop;
    logic [3:0]    cnt, cnt_n;
    logic [7:0]    sh, sh_n, byte_in, rd_cur, rd_nxt;
    logic [AW-1:0] ptr, ptr_n, ptr_inc;
    logic          rw, rw_n, sda_low, sda_low_n, busy, busy_n, strobe_n, mem_we;
    logic          wr_strobe;
    logic [7:0]    wr_addr, wr_data;
    logic [7:0]    mem [MEM_DEPTH];
    // Bytes never written read back as INIT_VALUE; the map relies on power-up zero and survives rst.
    logic [MEM_DEPTH-1:0] written;
    assign scl_rise = scl_m[1] & ~scl_d;
    assign scl_fall = ~scl_m[1] & scl_d;
    assign start    = scl_m[1] & scl_d & ~sda_m[1] & sda_d;
    assign stop     = scl_m[1] & scl_d & sda_m[1] & ~sda_d;
    assign byte_in  = {sh[6:0], sda_m[1]};
    assign ptr_inc  = ptr + AW'(1);
    assign rd_cur   = written[ptr] ? mem[ptr] : INIT_VALUE;
    assign rd_nxt   = written[ptr_inc] ? mem[ptr_inc] : INIT_VALUE;
    assign i2c_SDA  = sda_low ? 1'b0 : 1'bz;
    assign bus.busy      = busy;
    assign bus.wr_strobe = wr_strobe;
    assign bus.wr_addr   = wr_addr;
    assign bus.wr_data   = wr_data;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_m     <= 2'b11;
            sda_m     <= 2'b11;
            scl_d     <= 1'b1;
            sda_d     <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            sh        <= '0;
            ptr       <= '0;
            rw        <= 1'b0;
            sda_low   <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            scl_m     <= {scl_m[0], bus.i2c_SCL};
            sda_m     <= {sda_m[0], i2c_SDA};
            scl_d     <= scl_m[1];
            sda_d     <= sda_m[1];
            state     <= state_n;
            cnt       <= cnt_n;
            sh        <= sh_n;
            ptr       <= ptr_n;
            rw        <= rw_n;
            sda_low   <= sda_low_n;
            busy      <= busy_n;
            wr_strobe <= strobe_n;
            if (strobe_n) begin
                wr_addr <= 8'(ptr);
                wr_data <= byte_in;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr]     <= byte_in;
            written[ptr] <= 1'b1;
        end
    end
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        sh_n      = sh;
        ptr_n     = ptr;
        rw_n      = rw;
        sda_low_n = sda_low;
        busy_n    = busy;
        strobe_n  = 1'b0;
        mem_we    = 1'b0;
        if (start) begin
            state_n   = DEV_ADDR;
            cnt_n     = '0;
            sda_low_n = 1'b0;
            busy_n    = 1'b0;
        end else if (stop) begin
            state_n   = IDLE;
            sda_low_n = 1'b0;
            busy_n    = 1'b0;
        end else begin
            case (state)
                DEV_ADDR, WORD_ADDR, WR_DATA: if (scl_rise) begin
                    sh_n  = byte_in;
                    cnt_n = cnt + 4'd1;
                    if (cnt == 4'd7) begin
                        cnt_n = '0;
                        if (state == DEV_ADDR) begin
                            state_n = (byte_in[7:1] == SLV_ADDR) ? DEV_ACK : IGNORE;
                            rw_n    = byte_in[0];
                            busy_n  = (byte_in[7:1] == SLV_ADDR);
                        end else if (state == WORD_ADDR) begin
                            ptr_n   = byte_in[AW-1:0];
                            state_n = WORD_ACK;
                        end else begin
                            mem_we   = 1'b1;
                            strobe_n = 1'b1;
                            ptr_n    = ptr_inc;
                            state_n  = WR_ACK;
                        end
                    end
                end
                // First fall asserts the ACK, second fall ends it; a read drives its MSB on that same fall.
                DEV_ACK, WORD_ACK, WR_ACK: if (scl_fall) begin
                    if (cnt == 4'd0) begin
                        sda_low_n = 1'b1;
                        cnt_n     = 4'd1;
                    end else if (state == DEV_ACK && rw) begin
                        sh_n      = {rd_cur[6:0], 1'b0};
                        sda_low_n = ~rd_cur[7];
                        cnt_n     = 4'd1;
                        state_n   = RD_DATA;
                    end else begin
                        sda_low_n = 1'b0;
                        cnt_n     = '0;
                        state_n   = (state == DEV_ACK) ? WORD_ADDR : WR_DATA;
                    end
                end
                RD_DATA: if (scl_fall) begin
                    if (cnt == 4'd8) begin
                        sda_low_n = 1'b0;
                        cnt_n     = '0;
                        state_n   = RD_ACK;
                    end else begin
                        sda_low_n = ~sh[7];
                        sh_n      = {sh[6:0], 1'b0};
                        cnt_n     = cnt + 4'd1;
                    end
                end
                RD_ACK: if (scl_rise) begin
                    if (sda_m[1]) begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                    end else begin
                        ptr_n   = ptr_inc;
                        sh_n    = rd_nxt;
                        cnt_n   = '0;
                        state_n = RD_DATA;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// tb_i2c_eeprom_slave: directed I2C master transactions against the EEPROM target.
`timescale 1ns/1ps
module tb_i2c_eeprom_slave;
    localparam int Q = 80;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m_low = 1'b0;
    wire  sda;
    int   checks = 0, errors = 0;
    int   strb_cnt = 0, low_cnt = 0, busy_cnt = 0;
    logic [15:0] strb_log [64];
    i2c_eeprom_slave_if bus();
    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;
    i2c_eeprom_slave dut (.clk(clk), .rst(rst), .bus(bus), .i2c_SDA(sda));
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (bus.wr_strobe) begin
            strb_log[strb_cnt % 64] <= {bus.wr_addr, bus.wr_data};
            strb_cnt <= strb_cnt + 1;
        end
        if (bus.busy) busy_cnt <= busy_cnt + 1;
    end
    always @(negedge sda) if (!m_low) low_cnt++;
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic i2c_start();
        m_low = 1'b0; #Q;
        bus.i2c_SCL = 1'b1; #Q;
        m_low = 1'b1; #Q;
        bus.i2c_SCL = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        m_low = 1'b1; #Q;
        bus.i2c_SCL = 1'b1; #Q;
        m_low = 1'b0; #Q;
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic a);
        for (int i = 7; i >= 0; i--) begin
            m_low = ~b[i]; #Q;
            bus.i2c_SCL = 1'b1; #(2*Q);
            bus.i2c_SCL = 1'b0; #Q;
        end
        m_low = 1'b0; #Q;
        bus.i2c_SCL = 1'b1; #Q;
        a = sda; #Q;
        bus.i2c_SCL = 1'b0; #Q;
    endtask

    task automatic rd_byte(input logic ack_bit, output logic [7:0] d);
        d = '0;
        for (int i = 0; i < 8; i++) begin
            m_low = 1'b0; #Q;
            bus.i2c_SCL = 1'b1; #Q;
            d = {d[6:0], sda}; #Q;
            bus.i2c_SCL = 1'b0; #Q;
        end
        m_low = ~ack_bit; #Q;
        bus.i2c_SCL = 1'b1; #(2*Q);
        bus.i2c_SCL = 1'b0; #Q;
    endtask

    task automatic test_reset();
        bus.i2c_SCL = 1'b1;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checks += 5;
        if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b want 1", sda); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        if (bus.wr_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b want 0", bus.wr_strobe); end
        if (bus.wr_addr !== 8'h00) begin errors++; $display("FAIL reset_wr_addr: got %h want 00", bus.wr_addr); end
        if (bus.wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %h want 00", bus.wr_data); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_byte_write();
        logic a0, a1, a2;
        int s0;
        s0 = strb_cnt;
        i2c_start();
        wr_byte(8'hA0, a0);
        wr_byte(8'h10, a1);
        wr_byte(8'hA5, a2);
        i2c_stop();
        repeat (4) @(negedge clk);
        checks += 6;
        if (a0 !== 1'b0) begin errors++; $display("FAIL bw_ack_dev: got %b want 0", a0); end
        if (a1 !== 1'b0) begin errors++; $display("FAIL bw_ack_word: got %b want 0", a1); end
        if (a2 !== 1'b0) begin errors++; $display("FAIL bw_ack_data: got %b want 0", a2); end
        if (strb_cnt - s0 != 1) begin errors++; $display("FAIL bw_strobes: got %0d want 1", strb_cnt - s0); end
        if (strb_log[s0 % 64][15:8] !== 8'h10) begin errors++; $display("FAIL bw_wr_addr: got %h want 10", strb_log[s0 % 64][15:8]); end
        if (strb_log[s0 % 64][7:0] !== 8'hA5) begin errors++; $display("FAIL bw_wr_data: got %h want a5", strb_log[s0 % 64][7:0]); end
    endtask

    task automatic test_random_read();
        logic a0, a1, a2, b_mid;
        logic [7:0] d;
        i2c_start();
        wr_byte(8'hA0, a0);
        wr_byte(8'h10, a1);
        i2c_start();
        wr_byte(8'hA1, a2);
        b_mid = bus.busy;
        rd_byte(1'b1, d);
        checks += 6;
        if (sda !== 1'b1) begin errors++; $display("FAIL rr_release: got %b want 1", sda); end
        i2c_stop();
        repeat (4) @(negedge clk);
        if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL rr_acks: got %b want 000", {a0, a1, a2}); end
        if (b_mid !== 1'b1) begin errors++; $display("FAIL rr_busy_mid: got %b want 1", b_mid); end
        if (d !== 8'hA5) begin errors++; $display("FAIL rr_data: got %h want a5", d); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL rr_busy_end: got %b want 0", bus.busy); end
        if (sda !== 1'b1) begin errors++; $display("FAIL rr_sda_idle: got %b want 1", sda); end
    endtask

    task automatic test_seq_write_wrap();
        logic [4:0] a;
        logic a5;
        logic [7:0] d;
        logic [15:0] want [3];
        int s0;
        want[0] = 16'hFE11; want[1] = 16'hFF22; want[2] = 16'h0033;
        s0 = strb_cnt;
        i2c_start();
        wr_byte(8'hA0, a[0]);
        wr_byte(8'hFE, a[1]);
        wr_byte(8'h11, a[2]);
        wr_byte(8'h22, a[3]);
        wr_byte(8'h33, a[4]);
        i2c_stop();
        repeat (4) @(negedge clk);
        checks += 2;
        if (a !== 5'b00000) begin errors++; $display("FAIL sw_acks: got %b want 00000", a); end
        if (strb_cnt - s0 != 3) begin errors++; $display("FAIL sw_strobes: got %0d want 3", strb_cnt - s0); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (strb_log[(s0 + i) % 64] !== want[i]) begin
                errors++;
                $display("FAIL sw_commit%0d: got %h want %h", i, strb_log[(s0 + i) % 64], want[i]);
            end
        end
        i2c_start();
        wr_byte(8'hA1, a5);
        rd_byte(1'b1, d);
        i2c_stop();
        checks += 2;
        if (a5 !== 1'b0) begin errors++; $display("FAIL cr_ack: got %b want 0", a5); end
        if (d !== 8'hFF) begin errors++; $display("FAIL cr_data: got %h want ff", d); end
    endtask

    task automatic test_addr_mismatch();
        logic a0, a1;
        int s0, l0, b0;
        s0 = strb_cnt; l0 = low_cnt; b0 = busy_cnt;
        i2c_start();
        wr_byte(8'hA2, a0);
        wr_byte(8'hFF, a1);
        i2c_stop();
        repeat (4) @(negedge clk);
        checks += 4;
        if ({a0, a1} !== 2'b11) begin errors++; $display("FAIL mm_no_ack: got %b want 11", {a0, a1}); end
        if (low_cnt != l0) begin errors++; $display("FAIL mm_sda_driven: got %0d want 0", low_cnt - l0); end
        if (busy_cnt != b0) begin errors++; $display("FAIL mm_busy: got %0d want 0", busy_cnt - b0); end
        if (strb_cnt != s0) begin errors++; $display("FAIL mm_strobes: got %0d want 0", strb_cnt - s0); end
    endtask

    task automatic test_seq_read();
        logic a0, a1, a2;
        logic [7:0] d0, d1, d2;
        i2c_start();
        wr_byte(8'hA0, a0);
        wr_byte(8'hFE, a1);
        i2c_start();
        wr_byte(8'hA1, a2);
        rd_byte(1'b0, d0);
        rd_byte(1'b0, d1);
        rd_byte(1'b1, d2);
        i2c_stop();
        checks += 4;
        if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL sr_acks: got %b want 000", {a0, a1, a2}); end
        if (d0 !== 8'h11) begin errors++; $display("FAIL sr_byte0: got %h want 11", d0); end
        if (d1 !== 8'h22) begin errors++; $display("FAIL sr_byte1: got %h want 22", d1); end
        if (d2 !== 8'h33) begin errors++; $display("FAIL sr_byte2: got %h want 33", d2); end
    endtask

    task automatic test_abort();
        logic a0, a1, a2, b0, b1, b2, b3;
        logic [7:0] d;
        int s0, lows;
        i2c_start();
        wr_byte(8'hA0, a0);
        wr_byte(8'h10, a1);
        i2c_start();
        wr_byte(8'hA1, a2);
        for (int i = 0; i < 3; i++) begin
            m_low = 1'b0; #Q;
            bus.i2c_SCL = 1'b1; #(2*Q);
            bus.i2c_SCL = 1'b0; #Q;
        end
        m_low = 1'b0; #Q;
        bus.i2c_SCL = 1'b1; #Q;
        checks += 3;
        if (sda !== 1'b0) begin errors++; $display("FAIL ab_bit4_driven: got %b want 0", sda); end
        rst = 1'b1;
        #1;
        if (sda !== 1'b1) begin errors++; $display("FAIL ab_sda_release: got %b want 1", sda); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL ab_busy: got %b want 0", bus.busy); end
        #(Q - 1);
        bus.i2c_SCL = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #Q;
        lows = 0;
        for (int i = 0; i < 9; i++) begin
            bus.i2c_SCL = 1'b1; #Q;
            if (sda !== 1'b1) lows++;
            #Q;
            bus.i2c_SCL = 1'b0; #(2*Q);
        end
        checks++;
        if (lows != 0) begin errors++; $display("FAIL ab_idle_after_rst: got %0d low samples want 0", lows); end
        i2c_stop();
        s0 = strb_cnt;
        i2c_start();
        wr_byte(8'hA0, b0);
        wr_byte(8'h20, b1);
        wr_byte(8'h5A, b2);
        i2c_stop();
        repeat (4) @(negedge clk);
        checks += 3;
        if ({b0, b1, b2} !== 3'b000) begin errors++; $display("FAIL ab_wr_acks: got %b want 000", {b0, b1, b2}); end
        if (strb_cnt - s0 != 1) begin errors++; $display("FAIL ab_strobes: got %0d want 1", strb_cnt - s0); end
        if (strb_log[s0 % 64] !== 16'h205A) begin errors++; $display("FAIL ab_commit: got %h want 205a", strb_log[s0 % 64]); end
        i2c_start();
        wr_byte(8'hA0, b0);
        wr_byte(8'h20, b1);
        i2c_start();
        wr_byte(8'hA1, b3);
        rd_byte(1'b1, d);
        i2c_stop();
        checks++;
        if (d !== 8'h5A) begin errors++; $display("FAIL ab_readback: got %h want 5a", d); end
    endtask

    initial begin
        bus.i2c_SCL = 1'b1;
        @(negedge clk);
        test_reset();
        test_byte_write();
        test_random_read();
        test_seq_write_wrap();
        test_addr_mismatch();
        test_seq_read();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_eeprom_slave.md
Name: i2c_eeprom_slave

Overview:
Behavioural-synthesizable I2C target that emulates a 24Cxx-style byte EEPROM. It is the responder on the other end of the I2C bus driven by the APB EEPROM controller, and is used as the on-board/bench peer in FPGA demos and simulation. It decodes START/STOP, matches a 7-bit device address, and accepts a one-byte word address. It supports byte/sequential writes and current/random/sequential reads with auto-increment.

Parameters:
SLV_ADDR, 7'h50, 7-bit device address this target ACKs.
MEM_DEPTH, 256, number of bytes in the array; word address used modulo MEM_DEPTH (power of 2, ≤256).
INIT_VALUE, 8'hFF, power-up content of every memory byte (not reapplied on reset).

Ports:
clk  input  1  system clock, ≥ 8× SCL frequency.
rst  input  1  asynchronous active-high reset.
i2c_SCL  input  1  I2C clock from master; never stretched.
i2c_SDA  inout  1  I2C data; open drain: driven 1'b0 or 1'bz only.
busy  output  1  high from address match to the next START/STOP.
wr_strobe  output  1  one-clk pulse per byte committed to memory.
wr_addr  output  8  address of committed byte, valid with wr_strobe.
wr_data  output  8  committed byte, valid with wr_strobe.

Behaviour:
- Reset: SDA released (z), state IDLE, addr pointer 0, busy=0, wr_strobe=0, wr_addr=0, wr_data=0. Memory is not cleared.
- Input path: SCL and SDA each pass through a 2-flop synchroniser, then a registered edge detector. Bus events are seen 3 clk after the pin edge.
- START: SDA fall while SCL high. STOP: SDA rise while SCL high. Both are recognised in any state, including mid-byte.
- A START (or repeated START) moves the FSM to DEV_ADDR with bit count 0. A STOP moves it to IDLE and releases SDA.
- Data is sampled on SCL rise, MSB first. SDA drive changes only on a detected SCL fall.
- States:
  - IDLE: wait for START.
  - DEV_ADDR: shift 8 bits.
    - If [7:1]==SLV_ADDR, go to DEV_ACK and latch R/W.
    - Otherwise go to IGNORE (no ACK).
  - DEV_ACK: drive 0 from the next SCL fall to the following SCL fall.
    - W: go to WORD_ADDR.
    - R: go to RD_DATA and load mem[ptr].
  - WORD_ADDR: shift 8 bits, then ptr ← byte mod MEM_DEPTH; go to WORD_ACK (ACK), then WR_DATA.
  - WR_DATA: shift 8 bits.
    - At the 8th SCL rise: mem[ptr] ← byte, one-clk wr_strobe with wr_addr=ptr and wr_data=byte, ptr ← ptr+1 (wraps MEM_DEPTH-1 → 0).
    - Then WR_ACK (ACK), then WR_DATA again.
  - RD_DATA: drive shift-register bits (0 → drive low, 1 → release) on each SCL fall.
    - After the 8th bit, release SDA on the next fall and go to RD_ACK.
  - RD_ACK: sample the master bit at SCL rise.
    - 0 (ACK): ptr ← ptr+1 (wrap), load mem[ptr], go to RD_DATA.
    - 1 (NACK): go to IDLE, SDA stays released until the next START.
  - IGNORE: SDA released; wait for START/STOP.
- Current-address read: a START followed directly by address+R reads from ptr as left by the last access.
- Random read: address+W, word address, repeated START, then address+R.
- A STOP during WR_DATA mid-byte discards the partial byte; no write occurs.
- Asserting rst mid-transfer releases SDA within the same clk (async). The FSM resumes only at the next START.
- busy rises with the DEV_ACK entry and falls on START/STOP/NACK.

Test Plan:
- Byte write: START, 0xA0, 0x10, 0xA5, STOP → three ACKs (SDA=0 at 9th SCL rise); single wr_strobe with wr_addr=0x10, wr_data=0xA5; mem[0x10]=0xA5.
- Random read: START, 0xA0, 0x10, Sr, 0xA1, master NACK, STOP → byte 0xA5 on SDA MSB first; SDA released after the NACK; busy=0 after STOP.
- Sequential write wrap: START, 0xA0, 0xFE, 0x11, 0x22, 0x33, STOP → mem[0xFE]=0x11, mem[0xFF]=0x22, mem[0x00]=0x33; three wr_strobes; a follow-up current read returns mem[0x01] (0xFF from power-up).
- Address mismatch: START, 0xA2, … → SDA never driven low through the frame; busy stays 0; no wr_strobe.
- Sequential read: after the preceding writes, START, 0xA0, 0xFE, Sr, 0xA1, ACK, ACK, NACK → bytes 0x11, 0x22, 0x33 returned.
- Abort: rst asserted during the 4th bit of a read byte → SDA becomes z in the same cycle. After rst deasserts, the bus stays idle until START; a new write of 0x5A to 0x20 then succeeds.
